rtc_access_sched: RTL and testbench

Transaction scheduler sitting directly above the RTC bus-cycle FSM. It shares the single multiplexed address/data bus between a periodic time-refresh requester and a user register-write requester. For each transaction it issues one start pulse with direction, address and write data, then times the bus cycle to completion. Refresh reads of seconds, minutes and hours run as one atomic three-transaction burst, and the results are published as a coherent snapshot.

---
 rtl/rtc_access_sched_pkg.sv | 38 +++
 rtl/rtc_access_sched_if.sv | 27 ++
 rtl/rtc_bus_timer.sv | 28 ++
 rtl/rtc_access_sched.sv | 187 ++++++++++++++++++
 tb/tb_rtc_access_sched.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_access_sched_pkg.sv
// Shared types and default constants for the RTC access scheduler.
// Defines the scheduler state encoding, bus command payload and snapshot layout.
package rtc_access_sched_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned BUS_CYCLES_DEF = 36;

    localparam logic [DATA_W-1:0] ADDR_SEC_DEF  = 8'h21;
    localparam logic [DATA_W-1:0] ADDR_MIN_DEF  = 8'h22;
    localparam logic [DATA_W-1:0] ADDR_HOUR_DEF = 8'h23;
    localparam logic [DATA_W-1:0] INIT_ADDR_DEF = 8'h02;
    localparam logic [DATA_W-1:0] INIT_DATA_DEF = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT       = 3'd2,
        S_GAP        = 3'd3
`ifdef RTC_SCHED_INIT_EN
        ,
        S_INIT_ISSUE = 3'd4,
        S_INIT_WAIT  = 3'd5
`endif
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] hour;
        logic [DATA_W-1:0] min;
        logic [DATA_W-1:0] sec;
    } snapshot_t;

endpackage

// File: rtl/rtc_access_sched_if.sv
// User write handshake and RTC bus-FSM command/response signals.
// slave = scheduler side, master = requester / bus FSM side.
interface rtc_access_sched_if;
    import rtc_access_sched_pkg::*;

    logic              wr_req;
    logic [DATA_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              bus_go;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rd_flag;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output wr_req, wr_addr, wr_data, bus_rd_flag, bus_rdata,
        input  wr_ack, bus_go, bus_wr, bus_addr, bus_wdata
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, bus_rd_flag, bus_rdata,
        output wr_ack, bus_go, bus_wr, bus_addr, bus_wdata
    );

endinterface

// File: rtl/rtc_bus_timer.sv
// Loadable down-counter timing one bus transaction: start loads BUS_CYCLES-1,
// done_c is high once the count has expired (BUS_CYCLES cycles after start).
module rtc_bus_timer #(
    parameter int unsigned BUS_CYCLES = 36
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done_c
);

    localparam int unsigned CNT_W = (BUS_CYCLES > 1) ? $clog2(BUS_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(BUS_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/rtc_access_sched.sv
// Arbitrates user register writes and periodic sec/min/hour refresh bursts onto the
// RTC bus FSM. Optional power-up register write compiled in with RTC_SCHED_INIT_EN.
module rtc_access_sched
    import rtc_access_sched_pkg::*;
#(
    parameter int unsigned       BUS_CYCLES = BUS_CYCLES_DEF,
    parameter logic [DATA_W-1:0] ADDR_SEC   = ADDR_SEC_DEF,
    parameter logic [DATA_W-1:0] ADDR_MIN   = ADDR_MIN_DEF,
    parameter logic [DATA_W-1:0] ADDR_HOUR  = ADDR_HOUR_DEF,
    parameter logic [DATA_W-1:0] INIT_ADDR  = INIT_ADDR_DEF,
    parameter logic [DATA_W-1:0] INIT_DATA  = INIT_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    rtc_access_sched_if.slave bus,
    output logic [DATA_W-1:0] sec,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] hour,
    output logic              time_valid,
    output logic              busy
);

    state_t                   state_q, state_d;
    bus_cmd_t                 cmd_q, cmd_d;
    logic [1:0]               step_q, step_d;
    logic                     tick_pend_q, tick_pend_d;
    logic [2:0][DATA_W-1:0]   shadow_q, shadow_d;
    snapshot_t                snap_q, snap_d;
    logic                     bus_go_q, bus_go_d;
    logic                     wr_ack_q, wr_ack_d;
    logic                     time_valid_q, time_valid_d;
    logic                     busy_q, busy_d;
    logic                     timer_start_c;
    logic                     timer_done_c;

`ifdef RTC_SCHED_INIT_EN
    logic init_done_q, init_done_d;
`else
    logic [2*DATA_W-1:0] unused_init;
    assign unused_init = {INIT_ADDR, INIT_DATA};
`endif

    rtc_bus_timer #(.BUS_CYCLES(BUS_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (timer_start_c),
        .done_c (timer_done_c)
    );

`ifdef RTC_SCHED_INIT_EN
    assign timer_start_c = (state_q == S_ISSUE) || (state_q == S_INIT_ISSUE);
`else
    assign timer_start_c = (state_q == S_ISSUE);
`endif

    // Next-state and next-register values
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        step_d       = step_q;
        tick_pend_d  = tick_pend_q | tick;
        shadow_d     = shadow_q;
        snap_d       = snap_q;
        wr_ack_d     = 1'b0;
        time_valid_d = 1'b0;
`ifdef RTC_SCHED_INIT_EN
        init_done_d  = init_done_q;
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef RTC_SCHED_INIT_EN
                if (!init_done_q) begin
                    cmd_d   = '{wr: 1'b1, addr: INIT_ADDR, wdata: INIT_DATA};
                    state_d = S_INIT_ISSUE;
                end else
`endif
                // Writes win; the ack cycle masks wr_req so a held request is not re-issued
                if (bus.wr_req && !wr_ack_q) begin
                    cmd_d   = '{wr: 1'b1, addr: bus.wr_addr, wdata: bus.wr_data};
                    state_d = S_ISSUE;
                end else if (tick_pend_q || tick) begin
                    tick_pend_d = 1'b0;
                    step_d      = 2'd0;
                    cmd_d.wr    = 1'b0;
                    cmd_d.addr  = ADDR_SEC;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!cmd_q.wr && bus.bus_rd_flag) begin
                    unique case (step_q)
                        2'd0:    shadow_d[0] = bus.bus_rdata;
                        2'd1:    shadow_d[1] = bus.bus_rdata;
                        default: shadow_d[2] = bus.bus_rdata;
                    endcase
                end
                if (timer_done_c) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cmd_q.wr) begin
                    wr_ack_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (step_q != 2'd2) begin
                    step_d     = step_q + 2'd1;
                    cmd_d.addr = (step_q == 2'd0) ? ADDR_MIN : ADDR_HOUR;
                    state_d    = S_ISSUE;
                end else begin
                    snap_d       = '{hour: shadow_q[2], min: shadow_q[1], sec: shadow_q[0]};
                    time_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
`ifdef RTC_SCHED_INIT_EN
            S_INIT_ISSUE: begin
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (timer_done_c) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RTC_SCHED_INIT_EN
        bus_go_d = (state_d == S_ISSUE) || (state_d == S_INIT_ISSUE);
`else
        bus_go_d = (state_d == S_ISSUE);
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            step_q       <= 2'd0;
            tick_pend_q  <= 1'b0;
            shadow_q     <= '0;
            snap_q       <= '0;
            bus_go_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            time_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RTC_SCHED_INIT_EN
            init_done_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            step_q       <= step_d;
            tick_pend_q  <= tick_pend_d;
            shadow_q     <= shadow_d;
            snap_q       <= snap_d;
            bus_go_q     <= bus_go_d;
            wr_ack_q     <= wr_ack_d;
            time_valid_q <= time_valid_d;
            busy_q       <= busy_d;
`ifdef RTC_SCHED_INIT_EN
            init_done_q  <= init_done_d;
`endif
        end
    end

    assign bus.bus_go    = bus_go_q;
    assign bus.bus_wr    = cmd_q.wr;
    assign bus.bus_addr  = cmd_q.addr;
    assign bus.bus_wdata = cmd_q.wdata;
    assign bus.wr_ack    = wr_ack_q;
    assign sec           = snap_q.sec;
    assign min           = snap_q.min;
    assign hour          = snap_q.hour;
    assign time_valid    = time_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Scoreboard bench for rtc_access_sched: a transaction-level model predicts bus_go,
// wr_ack and time_valid events with their cycle; a negedge monitor checks them.
module tb_rtc_access_sched;
    import rtc_access_sched_pkg::*;

    localparam int TXN = 38;   // ISSUE + 36 WAIT + GAP

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic [7:0] sec, min, hour;
    logic       time_valid, busy;

    rtc_access_sched_if bif();

    rtc_access_sched #(.BUS_CYCLES(36)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .bus        (bif),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .time_valid (time_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;    // 0 bus_go, 1 wr_ack, 2 time_valid
        int         cyc;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] s, m, h;
    } evt_t;

    evt_t       exp_q[$];
    logic [7:0] resp_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         evt_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_evt(int kind, int c, logic wr, logic [7:0] a, logic [7:0] d,
                                     logic [7:0] s, logic [7:0] m, logic [7:0] h);
        evt_t e;
        e.kind = kind; e.cyc = c; e.wr = wr; e.addr = a; e.wdata = d;
        e.s = s; e.m = m; e.h = h;
        exp_q.push_back(e);
    endfunction

    // Reference model: scheduler is either free (arbitrates this cycle) or busy until next_arb
    int  next_arb = 0;
    int  ack_cyc  = -1;
    bit  pend     = 1'b0;
    int  bursts   = 0;
    logic [7:0] ms, mm, mh;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            resp_q.delete();
            pend     = 1'b0;
            next_arb = cyc + 1;
            ack_cyc  = -1;
        end else if (cyc < next_arb) begin
            if (tick) pend = 1'b1;
        end else if (bif.wr_req && cyc != ack_cyc) begin
            if (tick) pend = 1'b1;
            push_evt(0, cyc + 1, 1'b1, bif.wr_addr, bif.wr_data, 0, 0, 0);
            push_evt(1, cyc + 1 + TXN, 1'b0, 0, 0, 0, 0, 0);
            next_arb = cyc + 1 + TXN;
            ack_cyc  = next_arb;
        end else if (pend || tick) begin
            pend = 1'b0;
            if (bursts == 0) begin
                ms = 8'h45; mm = 8'h30; mh = 8'h12;
            end else begin
                ms = 8'($urandom); mm = 8'($urandom); mh = 8'($urandom);
            end
            bursts++;
            resp_q.push_back(ms); resp_q.push_back(mm); resp_q.push_back(mh);
            push_evt(0, cyc + 1,           1'b0, 8'h21, 0, 0, 0, 0);
            push_evt(0, cyc + 1 + TXN,     1'b0, 8'h22, 0, 0, 0, 0);
            push_evt(0, cyc + 1 + 2 * TXN, 1'b0, 8'h23, 0, 0, 0, 0);
            push_evt(2, cyc + 1 + 3 * TXN, 1'b0, 0, 0, ms, mm, mh);
            next_arb = cyc + 1 + 3 * TXN;
        end
    end

    // Bus FSM stand-in: a junk sample then the real one, so the last sample must win
    logic [7:0] resp_v;
    int         resp_d;
    initial begin
        bif.wr_req = 1'b0; bif.wr_addr = '0; bif.wr_data = '0;
        bif.bus_rd_flag = 1'b0; bif.bus_rdata = '0;
    end
    always @(negedge clk) begin
        if (!reset && bif.bus_go && !bif.bus_wr) begin
            resp_v = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hEE;
            resp_d = $urandom_range(4, 24);
            repeat (resp_d) @(posedge clk);
            #1 bif.bus_rd_flag = 1'b1; bif.bus_rdata = 8'($urandom);
            @(posedge clk);
            #1 bif.bus_rdata = resp_v;
            @(posedge clk);
            #1 bif.bus_rd_flag = 1'b0; bif.bus_rdata = 8'($urandom);
        end
    end

    // Monitor: pops one expected event whenever the DUT presents bus_go, wr_ack or time_valid
    bus_cmd_t   held;
    int         go_cyc = 0;
    bit         track = 1'b0, hold_bad = 1'b0;
    logic [7:0] ps = '0, pm = '0, ph = '0;
    logic [23:0] last_snap = '0;
    evt_t       e;
    int         akind;
    bit         ok;

    always @(negedge clk) begin
        if (reset) begin
            track     = 1'b0;
            last_snap = '0;
        end else begin
            if (bif.bus_go) begin
                held     = '{wr: bif.bus_wr, addr: bif.bus_addr, wdata: bif.bus_wdata};
                go_cyc   = cyc;
                track    = 1'b1;
                hold_bad = 1'b0;
            end else if (track) begin
                if ({bif.bus_wr, bif.bus_addr, bif.bus_wdata} != held) hold_bad = 1'b1;
                if (cyc == go_cyc + TXN - 1) begin
                    checks++;
                    if (hold_bad || !busy) begin
                        errors++;
                        $display("FAIL cmd_hold cyc=%0d: got changed=%b busy=%b, required changed=0 busy=1",
                                 cyc, hold_bad, busy);
                    end
                    track = 1'b0;
                end
            end

            if (bif.bus_go || bif.wr_ack || time_valid) begin
                evt_seen++;
                checks++;
                akind = bif.bus_go ? 0 : (bif.wr_ack ? 1 : 2);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d: got go=%b ack=%b tv=%b, required none",
                             cyc, bif.bus_go, bif.wr_ack, time_valid);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == akind) && (e.cyc == cyc);
                    if (akind == 0)
                        ok = ok && (bif.bus_wr == e.wr) && (bif.bus_addr == e.addr) &&
                             (!e.wr || bif.bus_wdata == e.wdata);
                    if (akind == 2)
                        ok = ok && ({hour, min, sec} == {e.h, e.m, e.s});
                    if (!ok) begin
                        errors++;
                        $display("FAIL event cyc=%0d: got kind=%0d wr=%b addr=%h wdata=%h hms=%h:%h:%h, required kind=%0d cyc=%0d wr=%b addr=%h wdata=%h hms=%h:%h:%h",
                                 cyc, akind, bif.bus_wr, bif.bus_addr, bif.bus_wdata, hour, min, sec,
                                 e.kind, e.cyc, e.wr, e.addr, e.wdata, e.h, e.m, e.s);
                    end
                end
                if (time_valid) begin
                    checks++;
                    if ({ph, pm, ps} != last_snap) begin
                        errors++;
                        $display("FAIL snapshot_stable cyc=%0d: got %h before time_valid, required %h",
                                 cyc, {ph, pm, ps}, last_snap);
                    end
                    last_snap = {hour, min, sec};
                end
            end
        end
        ps = sec; pm = min; ph = hour;
    end

    task automatic tick_pulse();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        bif.wr_req = 1'b1; bif.wr_addr = a; bif.wr_data = d;
        do begin
            @(negedge clk); n++;
        end while (!bif.wr_ack && n < 1000);
        checks++;
        if (!bif.wr_ack) begin
            errors++;
            $display("FAIL wr_ack_wait: got no wr_ack after %0d cycles, required one", n);
        end
        @(posedge clk); #1 bif.wr_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 2000) begin
            @(negedge clk); n++;
            if (exp_q.size() == 0 && !busy && !pend && !bif.wr_req && !tick) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 3) begin
            errors++;
            $display("FAIL drain_%s: got busy=%b outstanding=%0d after %0d cycles, required idle",
                     name, busy, exp_q.size(), n);
        end
    endtask

    task automatic check_zero(input string name);
        logic [61:0] v;
        v = {bif.bus_go, bif.bus_wr, bif.bus_addr, bif.bus_wdata, bif.wr_ack,
             sec, min, hour, time_valid, busy, 16'h0};
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s: got outputs=%h, required 0", name, v);
        end
    endtask

    task automatic scenario(input int kind);
        logic [7:0] a, d;
        a = 8'($urandom); d = 8'($urandom);
        case (kind)
            0: tick_pulse();
            1: do_write(a, d);
            2: fork tick_pulse(); do_write(a, d); join
            3: fork
                   tick_pulse();
                   begin repeat ($urandom_range(5, 100)) @(posedge clk); do_write(a, d); end
               join
            default: fork
                   tick_pulse();
                   begin
                       repeat (10) @(posedge clk); tick_pulse();
                       repeat (30) @(posedge clk); tick_pulse();
                       repeat (50) @(posedge clk); tick_pulse();
                   end
               join
        endcase
        drain($sformatf("k%0d", kind));
    endtask

    int ev0;

    initial begin
        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        reset = 1'b0;
        repeat (3) @(posedge clk);

        scenario(0);              // refresh burst alone (45/30/12)
        do_write(8'h24, 8'h07);   // single user write
        drain("write");
        scenario(2);              // simultaneous tick and write
        scenario(3);              // write during a burst
        scenario(4);              // ticks merging during a burst

        // Reset inside the second read of a burst
        tick_pulse();
        repeat (45) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("midreset_outputs");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        ev0 = evt_seen;
        repeat (200) @(posedge clk);
        checks++;
        if (evt_seen != ev0 || {hour, min, sec} != 24'h0) begin
            errors++;
            $display("FAIL post_reset_quiet: got events=%0d hms=%h, required 0 and 000000",
                     evt_seen - ev0, {hour, min, sec});
        end

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            scenario($urandom_range(0, 4));
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "watchdog");
    end

endmodule
